// File: rtl/cgra_mem_pkg.sv
// Shared definitions for the CGRA memory responder: default widths,
// mode FSM encoding and the write counter ceiling.
package cgra_mem_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int DEPTH_LOG2_DEF = 8;

   localparam logic [15:0] WRITE_COUNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOST_RSP = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } cgra_state_e;

   // Increment that sticks at the ceiling instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == WRITE_COUNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cgra_spram_32b.sv
// Single-port synchronous scratchpad. A read of the addressed word happens
// on every clock; on a write the registered output returns the old contents.
module cgra_spram_32b #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Storage write plus read-before-write registered read port.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
   end

endmodule

// File: rtl/cgra_mem_responder_32b.sv
// Memory-side responder for a CGRA memory port. The host loads and unloads
// the scratchpad while IDLE; between run_start and run_stop the CGRA owns it
// and performs one access per clock.
module cgra_mem_responder_32b
   import cgra_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  CGRA_Clock,
   input  logic                  CGRA_Reset,
   input  logic                  run_start,
   input  logic                  run_stop,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] to_mem,
   input  logic                  write_rq,
   output logic [DATA_WIDTH-1:0] from_mem,
   input  logic                  host_req_valid,
   output logic                  host_req_ready,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_rsp_valid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  running,
   output logic                  addr_err,
   output logic [15:0]           write_count,
   output logic [1:0]            state_dbg
);

   cgra_state_e state;

   logic [DEPTH_LOG2-1:0] cgra_idx, host_idx, ram_idx;
   logic                  cgra_in_range, host_in_range;
   logic                  cgra_acc, host_acc;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
   logic                  cgra_rd_q, cgra_oor_q, host_rd_q, host_oor_q;
   logic [DATA_WIDTH-1:0] from_mem_hold, host_rdata_hold;
   logic                  unused_byte_bits;

   // Byte-lane bits never select anything; the scratchpad is word-addressed.
   assign unused_byte_bits = ^{addr[1:0], host_addr[1:0]};

   assign cgra_idx      = addr[DEPTH_LOG2+1:2];
   assign host_idx      = host_addr[DEPTH_LOG2+1:2];
   assign cgra_in_range = (addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
   assign host_in_range = (host_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);

   // Host handshake: a request transfers on a clock edge where host_req_valid
   // and host_req_ready are both high. Ready is offered only in IDLE, only
   // out of reset, and is withdrawn when run_start claims the same cycle.
   // The response is a single host_rsp_valid pulse on the following cycle
   // and cannot be back-pressured.
   assign host_req_ready = CGRA_Reset && (state == IDLE) && !run_start;
   assign host_acc       = host_req_valid && host_req_ready;
   assign cgra_acc       = (state == RUN);
   assign state_dbg      = state;

   // Steer either the CGRA port (in RUN) or the host request onto the RAM.
   always_comb begin
      ram_we    = 1'b0;
      ram_idx   = host_idx;
      ram_wdata = host_wdata;
      if (cgra_acc) begin
         ram_idx   = cgra_idx;
         ram_wdata = to_mem;
         ram_we    = write_rq && cgra_in_range;
      end else if (host_acc) begin
         ram_we    = host_we && host_in_range;
      end
   end

   cgra_spram_32b #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_spram (
      .clk   (CGRA_Clock),
      .we    (ram_we),
      .idx   (ram_idx),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // The RAM output register is shared, so each consumer sees it only in the
   // cycle after its own access and otherwise holds its previous value.
   assign from_mem   = cgra_rd_q ? (cgra_oor_q ? '0 : ram_rdata) : from_mem_hold;
   assign host_rdata = host_rd_q ? (host_oor_q ? '0 : ram_rdata) : host_rdata_hold;

   // Track which requester owns the RAM output next cycle and keep held values.
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         cgra_rd_q       <= 1'b0;
         cgra_oor_q      <= 1'b0;
         host_rd_q       <= 1'b0;
         host_oor_q      <= 1'b0;
         from_mem_hold   <= '0;
         host_rdata_hold <= '0;
      end else begin
         cgra_rd_q       <= cgra_acc;
         cgra_oor_q      <= cgra_acc && !cgra_in_range;
         host_rd_q       <= host_acc && !host_we;
         host_oor_q      <= host_acc && !host_in_range;
         from_mem_hold   <= from_mem;
         host_rdata_hold <= host_rdata;
      end
   end

   // Mode FSM with its registered status outputs and run statistics.
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         state          <= IDLE;
         host_rsp_valid <= 1'b0;
         running        <= 1'b0;
         addr_err       <= 1'b0;
         write_count    <= '0;
      end else begin
         host_rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (run_start) begin
                  state       <= RUN;
                  running     <= 1'b1;
                  write_count <= '0;
                  addr_err    <= 1'b0;
               end else if (host_acc) begin
                  state          <= HOST_RSP;
                  host_rsp_valid <= 1'b1;
               end
            end
            HOST_RSP: begin
               state <= IDLE;
            end
            RUN: begin
               if (!cgra_in_range) addr_err <= 1'b1;
               if (write_rq && cgra_in_range) write_count <= sat_inc16(write_count);
               if (run_stop) state <= DRAIN;
            end
            DRAIN: begin
               state   <= IDLE;
               running <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cgra_mem_responder_32b.sv
// Directed bench for the CGRA memory responder: host load/unload, CGRA
// accesses in RUN, out-of-range handling, start/host collision, counter
// saturation and asynchronous reset.
module tb_cgra_mem_responder_32b;
   import cgra_mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        run_start, run_stop;
   logic [31:0] addr, to_mem, from_mem;
   logic        write_rq;
   logic        host_req_valid, host_req_ready, host_we;
   logic [31:0] host_addr, host_wdata, host_rdata;
   logic        host_rsp_valid, running, addr_err;
   logic [15:0] write_count;
   logic [1:0]  state_dbg;

   int vectors;
   int miscompares;

   cgra_mem_responder_32b dut (
      .CGRA_Clock     (clk),
      .CGRA_Reset     (rst_n),
      .run_start      (run_start),
      .run_stop       (run_stop),
      .addr           (addr),
      .to_mem         (to_mem),
      .write_rq       (write_rq),
      .from_mem       (from_mem),
      .host_req_valid (host_req_valid),
      .host_req_ready (host_req_ready),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_rsp_valid (host_rsp_valid),
      .host_rdata     (host_rdata),
      .running        (running),
      .addr_err       (addr_err),
      .write_count    (write_count),
      .state_dbg      (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Host transaction driver: handshake in IDLE, capture the response cycle.
   task automatic host_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output logic rsp, output logic [31:0] rd);
      host_req_valid = 1'b1;
      host_we        = we;
      host_addr      = a;
      host_wdata     = d;
      step();
      host_req_valid = 1'b0;
      rsp = host_rsp_valid;
      rd  = host_rdata;
      step();
   endtask

   // CGRA access driver: one access presented for one RUN cycle.
   task automatic cgra_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
      write_rq = we;
      addr     = a;
      to_mem   = d;
      step();
      write_rq = 1'b0;
      addr     = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      run_start = 0; run_stop = 0; addr = 0; to_mem = 0; write_rq = 0;
      host_req_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      #2;
      vectors++;
      if (host_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", host_req_ready); end
      vectors++;
      if ({from_mem, host_rdata, write_count} !== 80'h0) begin miscompares++; $display("FAIL reset_data: from_mem %h host_rdata %h write_count %h expected 0", from_mem, host_rdata, write_count); end
      vectors++;
      if ({host_rsp_valid, addr_err, running} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {host_rsp_valid, addr_err, running}); end
      step(); step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (state_dbg !== IDLE || host_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release: state %0d ready %b expected 0/1", state_dbg, host_req_ready); end
   endtask

   task automatic test_host_rw();
      logic        rsp;
      logic [31:0] rd;
      host_xfer(1'b1, 32'h10, 32'hDEADBEEF, rsp, rd);
      vectors++;
      if (rsp !== 1'b1) begin miscompares++; $display("FAIL host_wr_rsp: got %b expected 1", rsp); end
      vectors++;
      if (host_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL host_rsp_pulse: got %b expected 0", host_rsp_valid); end
      host_xfer(1'b0, 32'h10, 32'h0, rsp, rd);
      vectors++;
      if (rsp !== 1'b1 || rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL host_rd: rsp %b data %h expected 1/deadbeef", rsp, rd); end
      vectors++;
      if (host_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL host_rdata_hold: got %h expected deadbeef", host_rdata); end
      host_xfer(1'b1, 32'h0, 32'h0BADF00D, rsp, rd);
      host_xfer(1'b1, 32'h40, 32'h00000055, rsp, rd);
      host_xfer(1'b1, 32'h800, 32'h77777777, rsp, rd);
      vectors++;
      if (rsp !== 1'b1) begin miscompares++; $display("FAIL host_oor_wr_rsp: got %b expected 1", rsp); end
      host_xfer(1'b0, 32'h800, 32'h0, rsp, rd);
      vectors++;
      if (rsp !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL host_oor_rd: rsp %b data %h expected 1/0", rsp, rd); end
      vectors++;
      if (addr_err !== 1'b0) begin miscompares++; $display("FAIL host_oor_no_err: got %b expected 0", addr_err); end
      host_xfer(1'b0, 32'h0, 32'h0, rsp, rd);
      vectors++;
      if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL host_oor_dropped: got %h expected 0badf00d", rd); end
   endtask

   task automatic test_cgra_run();
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      vectors++;
      if (running !== 1'b1 || state_dbg !== RUN || host_req_ready !== 1'b0) begin miscompares++; $display("FAIL run_enter: running %b state %0d ready %b expected 1/2/0", running, state_dbg, host_req_ready); end
      cgra_cycle(1'b1, 32'h20, 32'h12345678);
      cgra_cycle(1'b0, 32'h20, 32'h0);
      vectors++;
      if (from_mem !== 32'h12345678) begin miscompares++; $display("FAIL cgra_rd: got %h expected 12345678", from_mem); end
      vectors++;
      if (write_count !== 16'd1 || host_req_ready !== 1'b0) begin miscompares++; $display("FAIL cgra_wcount: count %0d ready %b expected 1/0", write_count, host_req_ready); end
   endtask

   task automatic test_read_before_write();
      cgra_cycle(1'b1, 32'h40, 32'hAAAA0000);
      vectors++;
      if (from_mem !== 32'h00000055) begin miscompares++; $display("FAIL rbw_old: got %h expected 00000055", from_mem); end
      cgra_cycle(1'b0, 32'h43, 32'h0);
      vectors++;
      if (from_mem !== 32'hAAAA0000) begin miscompares++; $display("FAIL rbw_new: got %h expected aaaa0000", from_mem); end
      vectors++;
      if (write_count !== 16'd2) begin miscompares++; $display("FAIL rbw_wcount: got %0d expected 2", write_count); end
   endtask

   task automatic test_out_of_range();
      logic        rsp;
      logic [31:0] rd;
      cgra_cycle(1'b1, 32'h400, 32'hFFFFFFFF);
      vectors++;
      if (from_mem !== 32'h0 || addr_err !== 1'b1) begin miscompares++; $display("FAIL oor_access: from_mem %h addr_err %b expected 0/1", from_mem, addr_err); end
      vectors++;
      if (write_count !== 16'd2) begin miscompares++; $display("FAIL oor_wcount: got %0d expected 2", write_count); end
      run_stop = 1'b1;
      cgra_cycle(1'b0, 32'h20, 32'h0);
      run_stop = 1'b0;
      vectors++;
      if (from_mem !== 32'h12345678 || state_dbg !== DRAIN || running !== 1'b1) begin miscompares++; $display("FAIL stop_access: from_mem %h state %0d running %b expected 12345678/3/1", from_mem, state_dbg, running); end
      step();
      vectors++;
      if (state_dbg !== IDLE || running !== 1'b0 || host_req_ready !== 1'b1) begin miscompares++; $display("FAIL drain_exit: state %0d running %b ready %b expected 0/0/1", state_dbg, running, host_req_ready); end
      vectors++;
      if (from_mem !== 32'h12345678 || addr_err !== 1'b1) begin miscompares++; $display("FAIL idle_hold: from_mem %h addr_err %b expected 12345678/1", from_mem, addr_err); end
      host_xfer(1'b0, 32'h0, 32'h0, rsp, rd);
      vectors++;
      if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL oor_mem0: got %h expected 0badf00d", rd); end
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      vectors++;
      if (addr_err !== 1'b0 || write_count !== 16'd0) begin miscompares++; $display("FAIL start_clears: addr_err %b count %0d expected 0/0", addr_err, write_count); end
      run_stop = 1'b1;
      step();
      run_stop = 1'b0;
      step();
   endtask

   task automatic test_start_vs_host();
      run_start      = 1'b1;
      host_req_valid = 1'b1;
      host_we        = 1'b1;
      host_addr      = 32'h10;
      host_wdata     = 32'h11111111;
      #1;
      vectors++;
      if (host_req_ready !== 1'b0) begin miscompares++; $display("FAIL collide_ready: got %b expected 0", host_req_ready); end
      step();
      run_start      = 1'b0;
      host_req_valid = 1'b0;
      vectors++;
      if (running !== 1'b1 || host_rsp_valid !== 1'b0 || state_dbg !== RUN) begin miscompares++; $display("FAIL collide_run: running %b rsp %b state %0d expected 1/0/2", running, host_rsp_valid, state_dbg); end
      cgra_cycle(1'b0, 32'h10, 32'h0);
      vectors++;
      if (from_mem !== 32'hDEADBEEF) begin miscompares++; $display("FAIL collide_not_written: got %h expected deadbeef", from_mem); end
      run_stop = 1'b1;
      step();
      run_stop = 1'b0;
      vectors++;
      if (state_dbg !== DRAIN || host_req_ready !== 1'b0) begin miscompares++; $display("FAIL collide_drain: state %0d ready %b expected 3/0", state_dbg, host_req_ready); end
      step();
      vectors++;
      if (state_dbg !== IDLE || host_req_ready !== 1'b1 || running !== 1'b0) begin miscompares++; $display("FAIL collide_idle: state %0d ready %b running %b expected 0/1/0", state_dbg, host_req_ready, running); end
   endtask

   task automatic test_saturate_and_reset();
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      write_rq  = 1'b1;
      addr      = 32'h20;
      to_mem    = 32'hCAFE0001;
      for (int i = 0; i < 70000; i++) step();
      vectors++;
      if (write_count !== 16'hFFFF) begin miscompares++; $display("FAIL saturate: got %h expected ffff", write_count); end
      vectors++;
      if (from_mem !== 32'hCAFE0001 || host_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL pre_reset_data: from_mem %h host_rdata %h expected cafe0001/0badf00d", from_mem, host_rdata); end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({from_mem, host_rdata, write_count} !== 80'h0) begin miscompares++; $display("FAIL async_reset_data: from_mem %h host_rdata %h count %h expected 0", from_mem, host_rdata, write_count); end
      vectors++;
      if ({running, host_req_ready, host_rsp_valid, addr_err} !== 4'b0000) begin miscompares++; $display("FAIL async_reset_flags: got %b expected 0000", {running, host_req_ready, host_rsp_valid, addr_err}); end
      write_rq = 1'b0;
      addr     = 32'h0;
      step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (state_dbg !== IDLE || host_req_ready !== 1'b1 || running !== 1'b0) begin miscompares++; $display("FAIL post_reset: state %0d ready %b running %b expected 0/1/0", state_dbg, host_req_ready, running); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_host_rw();
      test_cgra_run();
      test_read_before_write();
      test_out_of_range();
      test_start_vs_host();
      test_saturate_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cgra_mem_responder_32b.md
Name: cgra_mem_responder_32b

Overview:
- Memory-side responder for a CGRA memory port. It is a word-addressed scratchpad that consumes the port's addr/to_mem/write_rq and returns data on from_mem.
- A host load/unload interface with a valid/ready handshake initialises and reads back the scratchpad between kernel runs.
- A small mode FSM arbitrates ownership between host and CGRA. It sits between the CGRA fabric edge and the SoC-side host adapter.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, width of the byte address from the memory port and from the host.
- DEPTH_LOG2, 8, log2 of the scratchpad depth in words (256 words).

Ports:
- CGRA_Clock  input  1  single clock for all logic.
- CGRA_Reset  input  1  asynchronous, active-low reset.
- run_start  input  1  one-cycle pulse; hands the memory to the CGRA.
- run_stop  input  1  one-cycle pulse; returns the memory to the host.
- addr  input  ADDR_WIDTH  byte address from the memory port.
- to_mem  input  DATA_WIDTH  write data from the memory port.
- write_rq  input  1  write request from the memory port; 0 means read.
- from_mem  output  DATA_WIDTH  registered read data to the memory port.
- host_req_valid  input  1  host request valid.
- host_req_ready  output  1  host request accepted when valid&ready.
- host_we  input  1  host write (1) / read (0).
- host_addr  input  ADDR_WIDTH  host byte address.
- host_wdata  input  DATA_WIDTH  host write data.
- host_rsp_valid  output  1  one-cycle pulse: read data valid, or write done.
- host_rdata  output  DATA_WIDTH  host read data.
- running  output  1  high in RUN and DRAIN.
- addr_err  output  1  sticky out-of-range flag; cleared on run_start.
- write_count  output  16  number of CGRA writes this run; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, CGRA_Reset=0):
  - State goes to IDLE.
  - from_mem, host_rdata, write_count = 0; host_rsp_valid, addr_err, running = 0; host_req_ready = 0 while in reset.
  - Scratchpad contents are not reset (undefined).
  - Reset mid-run aborts the run; the next cycle is in IDLE.
- Word index: addr[DEPTH_LOG2+1:2]; bits [1:0] are ignored. An address is in range iff addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == 0.
- FSM states: IDLE, HOST_RSP, RUN, DRAIN.
  - IDLE: host_req_ready=1.
    - valid&ready with host_we=1: write mem[idx]=host_wdata; go to HOST_RSP.
    - valid&ready with host_we=0: latch mem[idx] into host_rdata; go to HOST_RSP.
    - run_start: go to RUN; clear write_count and addr_err.
    - run_start and host_req_valid together: run_start wins; host_req_ready=0 that cycle and the request is not accepted.
  - HOST_RSP: host_rsp_valid=1 for exactly one cycle; host_req_ready=0; return to IDLE. A run_start arriving in HOST_RSP is ignored (the host must not issue it there).
  - RUN: host_req_ready=0; every cycle is a CGRA access.
    - write_rq=1 and in range: mem[idx]=to_mem; write_count+=1 (saturating).
    - Every cycle: from_mem <= mem[idx] (old data on a same-address write, i.e. read-before-write); read latency exactly 1 cycle.
    - Out of range: write dropped, from_mem <= 0, addr_err <= 1.
    - run_stop: go to DRAIN. The access in that same cycle is still performed.
    - run_start while in RUN is ignored.
  - DRAIN: no memory access; from_mem holds its value; go to IDLE. running=0 from IDLE onward.
- Host out-of-range access:
  - Write dropped; read returns 0; host_rsp_valid still pulses.
  - addr_err is set only by CGRA accesses.
- from_mem holds its last value outside RUN. host_rdata holds until the next host read.
- Only one host request is outstanding at a time. There is no backpressure on the response.

Decomposition:
- Shared package cgra_mem_pkg: state encoding constants (IDLE=2'd0, HOST_RSP=2'd1, RUN=2'd2, DRAIN=2'd3), default widths, and WRITE_COUNT_MAX=16'hFFFF.
- One sub-module: cgra_spram_32b, a single-port synchronous RAM with we, idx, wdata and registered rdata (read-before-write).
- The FSM, address checking and counters live in the top module, which muxes the host or CGRA request onto the RAM.

Test Plan:
- Host writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> the first host_rsp_valid pulses 1 cycle after the write handshake; the read returns host_rdata=0xDEADBEEF with host_rsp_valid one cycle after its handshake.
- run_start, then CGRA writes 0x12345678 @0x20 followed next cycle by a read @0x20 -> from_mem=0x12345678 one cycle after the read cycle; write_count=1; host_req_ready=0 throughout RUN.
- In RUN, write 0xAAAA0000 @0x40 with a same-cycle read of the same address (old value 0x55) -> from_mem=0x55 next cycle; a subsequent read gives 0xAAAA0000.
- In RUN, write to addr 0x400 (out of range for depth 256) -> from_mem=0, addr_err=1 and stays 1 after run_stop; the next run_start clears it; mem[0] is unchanged.
- run_start asserted together with host_req_valid in IDLE -> request not accepted; running=1 next cycle. Then run_stop -> DRAIN for 1 cycle, IDLE with host_req_ready=1 one cycle after that.
- Assert CGRA_Reset=0 mid-RUN after 70000 writes -> write_count had saturated at 0xFFFF; outputs go to 0 immediately (asynchronously); after release the FSM is in IDLE and host_req_ready=1.
